// File: rtl/dcache_port_arbiter_pkg.sv
// Shared encodings for the data-cache port arbiter: FSM states and the
// cache_we meaning of read versus write.
package dcache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOAD  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  localparam logic CACHE_OP_READ  = 1'b0;
  localparam logic CACHE_OP_WRITE = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
module arb_sat_counter #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (en && cnt != W'(MAX))   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Single data-cache port shared by MEM-stage loads and store-buffer drains.
// Drains happen only when the buffer is full, loads have starved it, or the port idles.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IDLE_WAIT  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_byte,
  input  logic              sb_empty,
  input  logic              sb_full,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [DATA_W-1:0] sb_data,
  input  logic              sb_byte,
  output logic              sb_pop,
  output logic              cache_req,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_byte,
  input  logic              cache_ready,
  output logic              ld_done,
  output logic              pipe_stall
);

  localparam int IW = $clog2(IDLE_WAIT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] starve_cnt;

  logic idle_st, force_drain, go_drain, go_load;
  logic idle_inc, starve_clr, starve_inc;

  always_comb begin
    idle_st     = (state == ARB_IDLE);
    force_drain = sb_full || (ld_req && !sb_empty && starve_cnt == SW'(STARVE_MAX));
    go_load     = idle_st && !force_drain && ld_req;
    go_drain    = idle_st && (force_drain ||
                  (!ld_req && !sb_empty && idle_cnt == IW'(IDLE_WAIT - 1)));
    idle_inc    = idle_st && !go_drain && !sb_empty && !ld_req;
    // Any drain resolves starvation; an empty buffer cannot be starved.
    starve_clr  = idle_st && (go_drain || sb_empty);
    starve_inc  = go_load && !sb_empty;
  end

  arb_sat_counter #(.W(IW), .MAX(IDLE_WAIT - 1)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!idle_inc),
    .en  (idle_inc),
    .cnt (idle_cnt)
  );

  arb_sat_counter #(.W(SW), .MAX(STARVE_MAX)) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .clr (starve_clr),
    .en  (starve_inc),
    .cnt (starve_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      cache_req   <= 1'b0;
      cache_we    <= CACHE_OP_READ;
      cache_addr  <= '0;
      cache_wdata <= '0;
      cache_byte  <= 1'b0;
      ld_done     <= 1'b0;
      sb_pop      <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      sb_pop  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (go_drain) begin
            state       <= ARB_DRAIN;
            cache_req   <= 1'b1;
            cache_we    <= CACHE_OP_WRITE;
            cache_addr  <= sb_addr;
            cache_wdata <= sb_data;
            cache_byte  <= sb_byte;
          end else if (go_load) begin
            state       <= ARB_LOAD;
            cache_req   <= 1'b1;
            cache_we    <= CACHE_OP_READ;
            cache_addr  <= ld_addr;
            cache_wdata <= '0;
            cache_byte  <= ld_byte;
          end
        end
        ARB_LOAD: begin
          if (cache_ready) begin
            state     <= ARB_IDLE;
            cache_req <= 1'b0;
            ld_done   <= 1'b1;
          end
        end
        ARB_DRAIN: begin
          if (cache_ready) begin
            state     <= ARB_IDLE;
            cache_req <= 1'b0;
            sb_pop    <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Released in the cycle the load's data returns so MEM can advance.
  assign pipe_stall = rst && ((ld_req && !(state == ARB_LOAD && cache_ready)) || sb_full);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench: expected cache accesses and responses are queued by the
// stimulus and checked by an independent monitor.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req, ld_byte, sb_empty, sb_full, sb_byte, cache_ready;
  logic [31:0] ld_addr, sb_addr, sb_data;
  logic        sb_pop, cache_req, cache_we, cache_byte, ld_done, pipe_stall;
  logic [31:0] cache_addr, cache_wdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bsel;
  } acc_t;

  acc_t exp_acc[$];
  bit   exp_rsp[$];   // 1 = sb_pop, 0 = ld_done

  int errors = 0;
  int checks = 0;
  bit resp_en = 1'b0;
  bit force_ready = 1'b0;
  int lat = 2;

  dcache_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_byte     (ld_byte),
    .sb_empty    (sb_empty),
    .sb_full     (sb_full),
    .sb_addr     (sb_addr),
    .sb_data     (sb_data),
    .sb_byte     (sb_byte),
    .sb_pop      (sb_pop),
    .cache_req   (cache_req),
    .cache_we    (cache_we),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_byte  (cache_byte),
    .cache_ready (cache_ready),
    .ld_done     (ld_done),
    .pipe_stall  (pipe_stall)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic b);
    acc_t e;
    e.we = we; e.addr = a; e.wdata = d; e.bsel = b;
    exp_acc.push_back(e);
  endtask

  task automatic wait_evt(input int max, output bit p, output bit d);
    p = 1'b0;
    d = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (sb_pop || ld_done) begin
        p = sb_pop;
        d = ld_done;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_evt: no response within %0d cycles", max);
  endtask

  // Cache model: answers each access with a one-cycle ready after lat cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    cache_ready = 1'b0;
    forever begin
      @(negedge clk);
      cache_ready = force_ready;
      if (cache_req && resp_en) begin
        wait_cnt++;
        if (wait_cnt == lat) begin
          cache_ready = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares every new access and every response pulse.
  initial begin
    logic prev_req;
    acc_t e;
    bit   r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (cache_req && !prev_req) begin
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL access_unexpected: got addr %0h we %0b, want none", cache_addr, cache_we);
        end else begin
          e = exp_acc.pop_front();
          if (cache_we !== e.we || cache_addr !== e.addr || cache_byte !== e.bsel ||
              (e.we && cache_wdata !== e.wdata)) begin
            errors++;
            $display("FAIL access: got we=%0b addr=%0h wdata=%0h byte=%0b want we=%0b addr=%0h wdata=%0h byte=%0b",
                     cache_we, cache_addr, cache_wdata, cache_byte, e.we, e.addr, e.wdata, e.bsel);
          end
        end
      end
      prev_req = cache_req;
      if (sb_pop || ld_done) begin
        checks++;
        if (exp_rsp.size() == 0 || (sb_pop && ld_done)) begin
          errors++;
          $display("FAIL response_unexpected: got pop=%0b done=%0b, want none", sb_pop, ld_done);
        end else begin
          r = exp_rsp.pop_front();
          if (sb_pop !== r) begin
            errors++;
            $display("FAIL response_kind: got pop=%0b done=%0b want pop=%0b", sb_pop, ld_done, r);
          end
        end
      end
    end
  end

  initial begin
    bit p, d, seen;
    int k;
    rst = 1'b0;
    ld_req = 1'b1; ld_addr = '0; ld_byte = 1'b0;
    sb_empty = 1'b1; sb_full = 1'b1; sb_addr = '0; sb_data = '0; sb_byte = 1'b0;

    // Reset state: every output low, stall masked even with requests present.
    repeat (3) tick();
    chk("reset_cache_req", cache_req, 0);
    chk("reset_pulses", {sb_pop, ld_done}, 0);
    chk("reset_pipe_stall", pipe_stall, 0);
    chk("reset_cache_bus", {cache_we, cache_byte, cache_addr, cache_wdata}, 0);
    ld_req = 1'b0; sb_full = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 1. Reset mid-drain, then the same entry drains again.
    sb_full = 1'b1; sb_empty = 1'b0; sb_addr = 32'h80; sb_data = 32'h1111_2222;
    push_acc(1'b1, 32'h80, 32'h1111_2222, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = cache_req;
    end
    chk("drain_started", seen, 1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("reset_mid_drain", {cache_req, cache_we, sb_pop, ld_done, pipe_stall, cache_addr}, 0);
    tick();
    tick();
    resp_en = 1'b1; lat = 2;
    push_acc(1'b1, 32'h80, 32'h1111_2222, 1'b0);
    exp_rsp.push_back(1'b1);
    rst = 1'b1;
    wait_evt(20, p, d);
    chk("redrain_pop", p, 1);
    sb_full = 1'b0; sb_empty = 1'b1;
    tick();

    // 2. Load on an empty buffer.
    lat = 3;
    ld_req = 1'b1; ld_addr = 32'h100; ld_byte = 1'b0;
    push_acc(1'b0, 32'h100, 32'h0, 1'b0);
    exp_rsp.push_back(1'b0);
    #1;
    chk("load_stall_issue", pipe_stall, 1);
    tick();
    chk("load_latency", {cache_req, cache_we, cache_addr}, {2'b10, 32'h100});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (cache_ready) begin
        seen = 1'b1;
        chk("load_stall_release", pipe_stall, 0);
        tick();
        chk("load_done_pulse", ld_done, 1);
        ld_req = 1'b0;
      end
    end
    chk("load_ready_seen", seen, 1);
    tick();

    // 3. Full buffer and load together: drain first, then the load.
    lat = 2;
    sb_full = 1'b1; sb_empty = 1'b0; sb_addr = 32'h40; sb_data = 32'hDEAD_BEEF; sb_byte = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h200; ld_byte = 1'b1;
    push_acc(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    push_acc(1'b0, 32'h200, 32'h0, 1'b1);
    exp_rsp.push_back(1'b1);
    exp_rsp.push_back(1'b0);
    #1;
    chk("full_stall", pipe_stall, 1);
    wait_evt(20, p, d);
    chk("full_drain_first", p, 1);
    sb_full = 1'b0; sb_empty = 1'b1;
    wait_evt(20, p, d);
    chk("full_load_second", d, 1);
    ld_req = 1'b0; ld_byte = 1'b0;
    tick();

    // 4. Starvation: three loads, one forced drain, then the fourth load.
    sb_empty = 1'b0; sb_addr = 32'h60; sb_data = 32'hCAFE_0004; sb_byte = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h300;
    push_acc(1'b0, 32'h300, 32'h0, 1'b0);
    push_acc(1'b0, 32'h304, 32'h0, 1'b0);
    push_acc(1'b0, 32'h308, 32'h0, 1'b0);
    push_acc(1'b1, 32'h60, 32'hCAFE_0004, 1'b0);
    push_acc(1'b0, 32'h30C, 32'h0, 1'b0);
    exp_rsp.push_back(1'b0);
    exp_rsp.push_back(1'b0);
    exp_rsp.push_back(1'b0);
    exp_rsp.push_back(1'b1);
    exp_rsp.push_back(1'b0);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      wait_evt(20, p, d);
      if (d) begin
        k++;
        ld_addr = 32'h300 + 32'(4 * k);
        if (k == 4) begin
          ld_req = 1'b0; sb_empty = 1'b1;
        end
      end
    end
    chk("starve_loads_done", k, 4);
    tick();

    // 5. Opportunistic drain exactly IDLE_WAIT cycles after the buffer fills.
    sb_empty = 1'b0; sb_addr = 32'h500; sb_data = 32'h55AA_55AA; sb_byte = 1'b1;
    push_acc(1'b1, 32'h500, 32'h55AA_55AA, 1'b1);
    exp_rsp.push_back(1'b1);
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      k++;
      seen = cache_req;
    end
    chk("idle_drain_delay", k, 4);
    wait_evt(20, p, d);
    chk("idle_drain_pop", p, 1);
    sb_empty = 1'b1;
    tick();

    // 6. Stray cache_ready in IDLE is ignored.
    resp_en = 1'b0;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ready_quiet", {cache_req, ld_done, sb_pop}, 0);
    end
    resp_en = 1'b1; lat = 1;
    ld_req = 1'b1; ld_addr = 32'h700; ld_byte = 1'b1;
    push_acc(1'b0, 32'h700, 32'h0, 1'b1);
    exp_rsp.push_back(1'b0);
    wait_evt(20, p, d);
    chk("post_stray_load", d, 1);
    ld_req = 1'b0;

    repeat (4) tick();
    chk("queues_drained", exp_acc.size() + exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
